pipelined_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor for the CSHM FIR multiplier datapath. Its carry chain is split into SEG-bit segments, one register stage per segment, so wide operands close timing at filter clock rates. It takes one operation per cycle with a valid/ready handshake on both sides. It reports carry-out and signed overflow, and can optionally saturate.

---
 rtl/pipelined_addsub_if.sv | 29 ++
 rtl/pipelined_addsub.sv | 150 +++++++++++++++
 tb/tb_pipelined_addsub.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_if.sv
// Operand/result stream bundle for pipelined_addsub (operands a/b/mode in, s/cout/ovf out).
// Latency: none, wires only.
// Backpressure: valid/ready on the operand side and on the result side.
interface pipelined_addsub_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, mode, a, b, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  // The adder/subtractor itself.
  modport slave (
    input  in_valid, mode, a, b, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Segmented-carry pipelined two's-complement add/sub with carry-out, signed overflow, optional clamp.
// Latency: L = W/SEG cycles, one beat per cycle when the result side keeps accepting.
// Backpressure: whole pipe freezes while a result waits unaccepted; in_ready follows that stall combinationally.
// Build option: define ADDSUB_SAT_EN to clamp s to the signed limit on overflow (default: wrap).
module pipelined_addsub #(
  parameter int W   = 16,
  parameter int SEG = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_addsub_if.slave bus
);

  localparam int L = W / SEG;

  // Global advance: the pipe moves unless a finished result is waiting.
  logic adv;

  // Per-stage inputs. st_x is a merged vector: bits below the stage's segment
  // already hold resolved sum bits, bits from the segment upward still hold
  // operand A. st_b is operand B, already inverted for subtraction.
  logic [W-1:0] st_x [L];
  logic [W-1:0] st_b [L];
  logic         st_c [L];
  logic         st_v [L];

  // Per-stage segment results.
  logic [SEG:0] seg_sum [L];
  logic [W-1:0] nx_x    [L];

  // Final-stage flags and (possibly clamped) sum.
  logic         fin_cin_msb;
  logic         fin_cout;
  logic         fin_ovf;
  logic [W-1:0] fin_s;

  // Pipeline registers.
  logic [W-1:0] x_q [L];
  logic [W-1:0] x_d [L];
  logic [W-1:0] b_q [L];
  logic [W-1:0] b_d [L];
  logic         c_q [L];
  logic         c_d [L];
  logic [L-1:0] vld_q;
  logic [L-1:0] vld_d;
  logic         cout_q;
  logic         cout_d;
  logic         ovf_q;
  logic         ovf_d;

  // Route each stage's inputs: stage 0 from the port, later stages from the previous register.
  always_comb begin
    st_x = '{default: '0};
    st_b = '{default: '0};
    st_c = '{default: 1'b0};
    st_v = '{default: 1'b0};
    st_x[0] = bus.a;
    st_b[0] = bus.mode ? ~bus.b : bus.b;
    st_c[0] = bus.mode;
    st_v[0] = bus.in_valid;
    for (int k = 1; k < L; k++) begin
      st_x[k] = x_q[k-1];
      st_b[k] = b_q[k-1];
      st_c[k] = c_q[k-1];
      st_v[k] = vld_q[k-1];
    end
  end

  // Resolve one SEG-bit slice per stage and splice it into the merged vector.
  always_comb begin
    seg_sum = '{default: '0};
    nx_x    = '{default: '0};
    for (int k = 0; k < L; k++) begin
      seg_sum[k] = {1'b0, st_x[k][k*SEG +: SEG]}
                 + {1'b0, st_b[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, st_c[k]};
      nx_x[k] = st_x[k];
      nx_x[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
    end
  end

  // Final stage: carry-out, signed overflow from the MSB carry pair, optional clamp.
  always_comb begin
    fin_cout = seg_sum[L-1][SEG];
    // Carry into the MSB recovered from sum = a ^ b ^ cin at that bit.
    fin_cin_msb = st_x[L-1][W-1] ^ st_b[L-1][W-1] ^ seg_sum[L-1][SEG-1];
    fin_ovf = fin_cin_msb ^ fin_cout;
    fin_s = nx_x[L-1];
`ifdef ADDSUB_SAT_EN
    // On overflow both adjusted sign bits agree; A's sign picks the limit.
    if (fin_ovf) begin
      fin_s = st_x[L-1][W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  // Next-state: every register (valid bits included) loads only when the pipe advances.
  always_comb begin
    adv   = bus.out_ready | ~vld_q[L-1];
    vld_d = vld_q;
    x_d   = x_q;
    b_d   = b_q;
    c_d   = c_q;
    for (int k = 0; k < L; k++) begin
      if (adv) begin
        vld_d[k] = st_v[k];
        x_d[k]   = nx_x[k];
        b_d[k]   = st_b[k];
        c_d[k]   = seg_sum[k][SEG];
      end
    end
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (adv) begin
      x_d[L-1] = fin_s;
      cout_d   = fin_cout;
      ovf_d    = fin_ovf;
    end
  end

  // State register; reset clears every stage so the output reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int k = 0; k < L; k++) begin
        x_q[k] <= '0;
        b_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else begin
      vld_q  <= vld_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      for (int k = 0; k < L; k++) begin
        x_q[k] <= x_d[k];
        b_q[k] <= b_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[L-1];
  assign bus.s         = x_q[L-1];
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench: directed vectors, streaming with backpressure, mid-flight reset,
// and random sweeps over (16,4), (16,16), (16,1), (32,8) against an integer reference.
// Expected values come from signed/unsigned integer arithmetic on the operands.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-DUT drive/observe slots, 64 bits wide so one set of tasks serves every width.
  logic [63:0] t_a [4];
  logic [63:0] t_b [4];
  logic        t_mode [4];
  logic        t_iv [4];
  logic        t_or [4];
  logic [63:0] t_s [4];
  logic        t_cout [4];
  logic        t_ovf [4];
  logic        t_ov [4];
  logic        t_ir [4];

  pipelined_addsub_if #(.W(16)) bus0 ();
  pipelined_addsub_if #(.W(16)) bus1 ();
  pipelined_addsub_if #(.W(16)) bus2 ();
  pipelined_addsub_if #(.W(32)) bus3 ();

  pipelined_addsub #(.W(16), .SEG(4))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pipelined_addsub #(.W(16), .SEG(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pipelined_addsub #(.W(16), .SEG(1))  dut2 (.clk(clk), .rst(rst), .bus(bus2));
  pipelined_addsub #(.W(32), .SEG(8))  dut3 (.clk(clk), .rst(rst), .bus(bus3));

`define TB_HOOK(BUS, N, WID) \
  assign BUS.a         = t_a[N][WID-1:0]; \
  assign BUS.b         = t_b[N][WID-1:0]; \
  assign BUS.mode      = t_mode[N]; \
  assign BUS.in_valid  = t_iv[N]; \
  assign BUS.out_ready = t_or[N]; \
  assign t_s[N]        = {{(64-WID){1'b0}}, BUS.s}; \
  assign t_cout[N]     = BUS.cout; \
  assign t_ovf[N]      = BUS.ovf; \
  assign t_ov[N]       = BUS.out_valid; \
  assign t_ir[N]       = BUS.in_ready;

  `TB_HOOK(bus0, 0, 16)
  `TB_HOOK(bus1, 1, 16)
  `TB_HOOK(bus2, 2, 16)
  `TB_HOOK(bus3, 3, 32)

  typedef struct packed {
    logic [65:0] res;
    int          acc;
  } beat_t;

`ifdef ADDSUB_SAT_EN
  localparam logic [63:0] POS_OVF_S = 64'h7FFF;
  localparam logic [63:0] NEG_OVF_S = 64'h8000;
`else
  localparam logic [63:0] POS_OVF_S = 64'h8000;
  localparam logic [63:0] NEG_OVF_S = 64'h7FFF;
`endif

  function automatic int dw(int d);
    return (d == 3) ? 32 : 16;
  endfunction

  function automatic int dl(int d);
    case (d)
      0:       return 4;
      1:       return 1;
      2:       return 16;
      default: return 4;
    endcase
  endfunction

  // Reference: exact signed result, range test for overflow, unsigned compare for carry.
  function automatic logic [65:0] ref_op(int w, logic [63:0] a, logic [63:0] b, logic mode);
    longint      sa, sb, ex, mx, mn;
    logic [63:0] mask, s;
    logic        c, o;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'(a);
    sb = longint'(b);
    if (a[w-1]) sa = sa - longint'(64'd1 << w);
    if (b[w-1]) sb = sb - longint'(64'd1 << w);
    ex = mode ? (sa - sb) : (sa + sb);
    mx = (longint'(1) << (w-1)) - 1;
    mn = -mx - 1;
    o  = (ex > mx) || (ex < mn);
    c  = mode ? (a >= b) : (((a + b) >> w) != 64'd0);
    s  = 64'(ex) & mask;
`ifdef ADDSUB_SAT_EN
    if (o) s = ((ex > mx) ? 64'(mx) : 64'(mn)) & mask;
`endif
    return {c, o, s};
  endfunction

  function automatic logic [63:0] rnd_op(int w);
    logic [63:0] mask, v;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0:       v = 64'd0;
      1:       v = mask;
      2:       v = 64'd1 << (w-1);
      3:       v = (64'd1 << (w-1)) - 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v & mask;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat on the default config; checks latency and all result fields.
  task automatic directed(string tag, logic [63:0] a, logic [63:0] b, logic mode,
                          logic [63:0] es, logic ec, logic eo);
    int acc, lat;
    t_a[0] = a; t_b[0] = b; t_mode[0] = mode; t_iv[0] = 1'b1; t_or[0] = 1'b1;
    #1;
    chk({tag, "_in_ready"}, t_ir[0], 1);
    tick();
    acc = cyc;
    t_iv[0] = 1'b0;
    lat = -1;
    for (int i = 0; i < 12 && lat < 0; i++) begin
      if (t_ov[0]) lat = cyc - acc + 1;
      else tick();
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_s"}, t_s[0], es);
    chk({tag, "_cout"}, t_cout[0], ec);
    chk({tag, "_ovf"}, t_ovf[0], eo);
    tick();
  endtask

  // Continuous random beats on the default config with a stall once the pipe is full.
  task automatic stream(int n, int stall_at, int stall_len);
    logic [65:0] q[$];
    logic [65:0] e;
    int sent, got, stall_cnt, first_o, last_o;
    bit have, stalling;
    sent = 0; got = 0; stall_cnt = 0; first_o = -1; last_o = -1; have = 1'b0;
    for (int w = 0; w < 200 && got < n; w++) begin
      stalling = (got == stall_at) && (stall_cnt < stall_len);
      if (stalling) stall_cnt++;
      t_or[0] = !stalling;
      if (!have && sent < n) begin
        t_a[0] = rnd_op(16); t_b[0] = rnd_op(16); t_mode[0] = 1'($urandom_range(0, 1));
        have = 1'b1;
      end
      t_iv[0] = have;
      #1;
      if (stalling) begin
        chk("stall_in_ready", t_ir[0], 0);
        chk("stall_out_valid", t_ov[0], 1);
        if (q.size() == 0) chk("stall_queue_empty", 1, 0);
        else chk("stall_hold", {t_cout[0], t_ovf[0], t_s[0]}, q[0]);
      end
      if (t_ov[0] && t_or[0]) begin
        if (q.size() == 0) chk("stream_extra_beat", 1, 0);
        else begin
          e = q.pop_front();
          chk("stream_res", {t_cout[0], t_ovf[0], t_s[0]}, e);
        end
        if (first_o < 0) first_o = cyc;
        last_o = cyc;
        got++;
      end
      if (have && t_ir[0]) begin
        q.push_back(ref_op(16, t_a[0], t_b[0], t_mode[0]));
        sent++;
        have = 1'b0;
      end
      tick();
    end
    t_iv[0] = 1'b0;
    chk("stream_count", got, n);
    chk("stream_leftover", q.size(), 0);
    chk("stream_no_bubble", last_o - first_o + 1, n + stall_len);
  endtask

  // Three beats in flight, one reset cycle, then a fresh beat must be the only one out.
  task automatic reset_mid();
    logic [65:0] e;
    int acc, seen, lat;
    for (int i = 0; i < 3; i++) begin
      t_a[0] = rnd_op(16); t_b[0] = rnd_op(16); t_mode[0] = 1'($urandom_range(0, 1));
      t_iv[0] = 1'b1; t_or[0] = 1'b1;
      tick();
    end
    chk("mid_pre_out_valid", t_ov[0], 0);
    rst = 1'b1;
    t_a[0] = 64'h1234; t_b[0] = 64'h0101; t_iv[0] = 1'b1;
    tick();
    rst = 1'b0; t_iv[0] = 1'b0; t_or[0] = 1'b0;
    #1;
    chk("mid_rst_out_valid", t_ov[0], 0);
    chk("mid_rst_s", t_s[0], 0);
    chk("mid_rst_cout", t_cout[0], 0);
    chk("mid_rst_ovf", t_ovf[0], 0);
    chk("mid_rst_in_ready", t_ir[0], 1);
    t_a[0] = rnd_op(16); t_b[0] = rnd_op(16); t_mode[0] = 1'($urandom_range(0, 1));
    e = ref_op(16, t_a[0], t_b[0], t_mode[0]);
    t_iv[0] = 1'b1; t_or[0] = 1'b1;
    tick();
    acc = cyc;
    t_iv[0] = 1'b0;
    seen = 0; lat = -1;
    for (int w = 0; w < 20; w++) begin
      if (t_ov[0]) begin
        seen++;
        if (lat < 0) begin
          lat = cyc - acc + 1;
          chk("mid_new_res", {t_cout[0], t_ovf[0], t_s[0]}, e);
        end
      end
      tick();
    end
    chk("mid_beats_seen", seen, 1);
    chk("mid_latency", lat, 4);
  endtask

  // Random sweep on one DUT: gappy input, always-ready output, latency and value per beat.
  task automatic sweep(int d, int n);
    beat_t q[$];
    beat_t e;
    int w, lat, sent, got;
    bit have;
    w = dw(d); lat = dl(d);
    sent = 0; got = 0; have = 1'b0;
    t_or[d] = 1'b1;
    for (int c = 0; c < n * 4 + 100 && got < n; c++) begin
      if (!have && sent < n && $urandom_range(0, 3) != 0) begin
        t_a[d] = rnd_op(w); t_b[d] = rnd_op(w); t_mode[d] = 1'($urandom_range(0, 1));
        have = 1'b1;
      end
      t_iv[d] = have;
      #1;
      if (t_ov[d]) begin
        if (q.size() == 0) chk("sweep_extra_beat", d, 99);
        else begin
          e = q.pop_front();
          chk("sweep_res", {t_cout[d], t_ovf[d], t_s[d]}, e.res);
          chk("sweep_latency", cyc - e.acc + 1, lat);
        end
        got++;
      end
      if (have && t_ir[d]) begin
        q.push_back('{res: ref_op(w, t_a[d], t_b[d], t_mode[d]), acc: cyc + 1});
        sent++;
        have = 1'b0;
      end
      tick();
    end
    t_iv[d] = 1'b0;
    chk("sweep_count", got, n);
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      t_a[d] = '0; t_b[d] = '0; t_mode[d] = 1'b0; t_iv[d] = 1'b0; t_or[d] = 1'b0;
    end
    rst = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 4; d++) begin
      chk("reset_out_valid", t_ov[d], 0);
      chk("reset_s", t_s[d], 0);
      chk("reset_cout", t_cout[d], 0);
      chk("reset_ovf", t_ovf[d], 0);
      chk("reset_in_ready", t_ir[d], 1);
    end
    rst = 1'b0;
    tick();

    directed("add_neg",  64'hFFFD, 64'hFFFE, 1'b0, 64'hFFFB, 1'b1, 1'b0);
    directed("sub_3m2",  64'h0003, 64'hFFFE, 1'b1, 64'h0005, 1'b0, 1'b0);
    directed("sub_3p2",  64'h0003, 64'h0002, 1'b1, 64'h0001, 1'b1, 1'b0);
    directed("ovf_add",  64'h7FFF, 64'h0001, 1'b0, POS_OVF_S, 1'b0, 1'b1);
    directed("ovf_sub",  64'h8000, 64'h0001, 1'b1, NEG_OVF_S, 1'b1, 1'b1);
    directed("add_zero", 64'h0000, 64'h0000, 1'b0, 64'h0000, 1'b0, 1'b0);

    stream(12, 4, 3);
    reset_mid();

    sweep(0, 300);
    sweep(1, 1000);
    sweep(2, 1000);
    sweep(3, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
